// File: rtl/capi_get_sched_pkg.sv
// Shared constants and types for the get-data read-stream scheduler.
package capi_get_sched_pkg;

    localparam int unsigned LINE_BYTES = 128;
    localparam int unsigned LINE_OFF_W = 7;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

endpackage

// File: rtl/capi_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer; the pointer advances to grant+1 whenever a grant is issued.
module capi_rr_arb #(
    parameter int unsigned n_req = 4,
    parameter int unsigned ptr_w = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [n_req-1:0] i_req,
    input  logic             i_en,
    output logic [n_req-1:0] o_gnt,
    output logic             o_gnt_v,
    output logic [ptr_w-1:0] o_gnt_idx
);

    logic [ptr_w-1:0] r_ptr;
    logic             w_found;
    logic [ptr_w-1:0] w_idx;
    int unsigned      w_k;

    // Scan from the pointer, wrapping at n_req, and keep the first hit.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_k     = 0;
        for (int unsigned i = 0; i < n_req; i++) begin
            w_k = 32'(r_ptr) + i;
            if (w_k >= n_req) begin
                w_k = w_k - n_req;
            end
            if (!w_found && i_req[ptr_w'(w_k)]) begin
                w_found = 1'b1;
                w_idx   = ptr_w'(w_k);
            end
        end
    end

    // Grant is only visible while the scheduler allows it.
    always_comb begin
        o_gnt = '0;
        if (w_found && i_en) begin
            o_gnt[w_idx] = 1'b1;
        end
    end

    assign o_gnt_v   = w_found & i_en;
    assign o_gnt_idx = w_idx;

    // Pointer moves past the granted stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (o_gnt_v) begin
            r_ptr <= (w_idx == ptr_w'(n_req - 1)) ? '0 : w_idx + ptr_w'(1);
        end
    end

endmodule

// File: rtl/capi_get_sched.sv
// Read-stream scheduler: grants one requester at a time, splits its (ea, len)
// into 128-byte line reads and pairs each consumed get-data tag with one
// command, driving per-tag byte trims and the end-of-stream flag.
// Vector ports carry stream 0 in the MSBs (i_req_v/i_req_r bit n_req-1).
module capi_get_sched
    import capi_get_sched_pkg::*;
#(
    parameter int unsigned n_req         = 4,
    parameter int unsigned sid_width     = 2,
    parameter int unsigned ea_width      = 64,
    parameter int unsigned len_width     = 16,
    parameter int unsigned lcl_tag_width = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [n_req-1:0]               i_req_v,
    output logic [n_req-1:0]               i_req_r,
    input  logic [n_req*ea_width-1:0]      i_req_ea,
    input  logic [n_req*len_width-1:0]     i_req_len,
    input  logic                           i_tag_v,
    output logic                           o_tag_r,
    input  logic [lcl_tag_width-1:0]       i_tag_d,
    output logic                           o_tag_e,
    output logic [LINE_OFF_W-1:0]          o_tag_ea_lsb,
    output logic [LINE_OFF_W-1:0]          o_tag_ea_lsb_nxt,
    output logic                           o_cmd_v,
    input  logic                           i_cmd_r,
    output logic [lcl_tag_width-1:0]       o_cmd_tag,
    output logic [ea_width-1:0]            o_cmd_ea,
    output logic [sid_width-1:0]           o_cmd_sid,
    input  logic                           i_disable,
    output logic                           o_busy
);

    localparam int unsigned LINE_W = ea_width - LINE_OFF_W;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ea_width-1:0]      r_cur;
    logic [ea_width-1:0]      r_end;
    logic [sid_width-1:0]     r_sid;
    logic                     r_cmd_v;
    logic [lcl_tag_width-1:0] r_cmd_tag;
    logic [ea_width-1:0]      r_cmd_ea;
    logic [sid_width-1:0]     r_cmd_sid;

    logic [n_req-1:0]         w_req;
    logic [n_req-1:0]         w_gnt;
    logic                     w_gnt_v;
    logic [sid_width-1:0]     w_gnt_idx;
    logic                     w_gnt_en;
    logic [ea_width-1:0]      w_sel_ea;
    logic [len_width-1:0]     w_sel_len;
    logic                     w_xfer;
    logic [LINE_W-1:0]        w_end_line;
    logic                     w_last;
    logic                     w_tag_act;

    assign w_gnt_en = (r_state == IDLE) && !i_disable;

    capi_rr_arb #(
        .n_req (n_req),
        .ptr_w (sid_width)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     (w_req),
        .i_en      (w_gnt_en),
        .o_gnt     (w_gnt),
        .o_gnt_v   (w_gnt_v),
        .o_gnt_idx (w_gnt_idx)
    );

    // Map MSB-first stream vectors to the arbiter and select the granted request.
    always_comb begin
        w_req     = '0;
        i_req_r   = '0;
        w_sel_ea  = '0;
        w_sel_len = '0;
        for (int unsigned k = 0; k < n_req; k++) begin
            w_req[k]             = i_req_v[n_req-1-k];
            i_req_r[n_req-1-k]   = w_gnt[k];
            if (w_gnt_idx == sid_width'(k)) begin
                w_sel_ea  = i_req_ea[(n_req-1-k)*ea_width +: ea_width];
                w_sel_len = i_req_len[(n_req-1-k)*len_width +: len_width];
            end
        end
    end

    // Line holding byte end-1: end's line, minus one when end is line-aligned.
    assign w_end_line = r_end[ea_width-1:LINE_OFF_W]
                      - LINE_W'(r_end[LINE_OFF_W-1:0] == '0);

    assign w_xfer           = (r_state == XFER);
    assign w_last           = w_xfer && (r_cur[ea_width-1:LINE_OFF_W] == w_end_line);
    assign o_tag_r          = w_xfer && (!r_cmd_v || i_cmd_r);
    assign w_tag_act        = i_tag_v && o_tag_r;
    assign o_tag_e          = w_last;
    assign o_tag_ea_lsb     = w_xfer ? r_cur[LINE_OFF_W-1:0] : '0;
    assign o_tag_ea_lsb_nxt = w_last ? r_end[LINE_OFF_W-1:0] : '0;

    assign o_cmd_v   = r_cmd_v;
    assign o_cmd_tag = r_cmd_tag;
    assign o_cmd_ea  = r_cmd_ea;
    assign o_cmd_sid = r_cmd_sid;
    assign o_busy    = w_xfer || r_cmd_v;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: zero-length grants are dropped; the last tag ends the stream.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_gnt_v && (w_sel_len != '0)) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if (w_tag_act && w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Stream window: latched on grant, cursor walks line by line on each tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur <= '0;
            r_end <= '0;
            r_sid <= '0;
        end else if (w_gnt_v) begin
            r_cur <= w_sel_ea;
            r_end <= w_sel_ea + ea_width'(w_sel_len);
            r_sid <= w_gnt_idx;
        end else if (w_tag_act) begin
            r_cur <= {r_cur[ea_width-1:LINE_OFF_W] + LINE_W'(1), {LINE_OFF_W{1'b0}}};
        end
    end

    // Command register: loaded per consumed tag, cleared when accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_v   <= 1'b0;
            r_cmd_tag <= '0;
            r_cmd_ea  <= '0;
            r_cmd_sid <= '0;
        end else if (w_tag_act) begin
            r_cmd_v   <= 1'b1;
            r_cmd_tag <= i_tag_d;
            r_cmd_ea  <= {r_cur[ea_width-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            r_cmd_sid <= r_sid;
        end else if (i_cmd_r) begin
            r_cmd_v   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_capi_get_sched.sv
// Directed bench for capi_get_sched with hand-computed per-tag expectations.
module tb_capi_get_sched;

    logic         clk;
    logic         reset;
    logic [3:0]   i_req_v;
    logic [3:0]   i_req_r;
    logic [255:0] i_req_ea;
    logic [63:0]  i_req_len;
    logic         i_tag_v;
    logic         o_tag_r;
    logic [3:0]   i_tag_d;
    logic         o_tag_e;
    logic [6:0]   o_tag_ea_lsb;
    logic [6:0]   o_tag_ea_lsb_nxt;
    logic         o_cmd_v;
    logic         i_cmd_r;
    logic [3:0]   o_cmd_tag;
    logic [63:0]  o_cmd_ea;
    logic [1:0]   o_cmd_sid;
    logic         i_disable;
    logic         o_busy;

    int           n_chk;
    int           n_err;
    logic [3:0]   tagcnt;

    capi_get_sched u_dut (
        .clk              (clk),
        .reset            (reset),
        .i_req_v          (i_req_v),
        .i_req_r          (i_req_r),
        .i_req_ea         (i_req_ea),
        .i_req_len        (i_req_len),
        .i_tag_v          (i_tag_v),
        .o_tag_r          (o_tag_r),
        .i_tag_d          (i_tag_d),
        .o_tag_e          (o_tag_e),
        .o_tag_ea_lsb     (o_tag_ea_lsb),
        .o_tag_ea_lsb_nxt (o_tag_ea_lsb_nxt),
        .o_cmd_v          (o_cmd_v),
        .i_cmd_r          (i_cmd_r),
        .o_cmd_tag        (o_cmd_tag),
        .o_cmd_ea         (o_cmd_ea),
        .o_cmd_sid        (o_cmd_sid),
        .i_disable        (i_disable),
        .o_busy           (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_slot(input int k, input logic [63:0] ea, input logic [15:0] len, input logic v);
        i_req_ea[(3-k)*64 +: 64]  = ea;
        i_req_len[(3-k)*16 +: 16] = len;
        i_req_v[3-k]              = v;
    endtask

    // Offer a single request in IDLE, expect an immediate grant, drop it after the edge.
    task automatic grant(input int k, input logic [63:0] ea, input logic [15:0] len);
        logic [3:0] exp_r;
        exp_r = 4'b1000 >> k;
        set_slot(k, ea, len, 1'b1);
        #1;
        chk("grant", 64'(i_req_r), 64'(exp_r));
        @(posedge clk);
        #1;
        i_req_v[3-k] = 1'b0;
    endtask

    // Wait for o_tag_r, check the tag trims, let one tag go and check the command.
    task automatic expect_tag(input string nm, input int sid, input logic [63:0] line_ea,
                              input logic [6:0] lsb, input logic [6:0] nxt, input logic e);
        int n;
        n = 0;
        i_tag_d = tagcnt;
        #1;
        while (o_tag_r !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_tag_r"}, 64'(o_tag_r), 64'(1));
        chk({nm, "_lsb"}, 64'(o_tag_ea_lsb), 64'(lsb));
        chk({nm, "_nxt"}, 64'(o_tag_ea_lsb_nxt), 64'(nxt));
        chk({nm, "_e"}, 64'(o_tag_e), 64'(e));
        @(posedge clk);
        #1;
        chk({nm, "_cmd_v"}, 64'(o_cmd_v), 64'(1));
        chk({nm, "_cmd_tag"}, 64'(o_cmd_tag), 64'(tagcnt));
        chk({nm, "_cmd_ea"}, o_cmd_ea, line_ea);
        chk({nm, "_cmd_sid"}, 64'(o_cmd_sid), 64'(sid));
        tagcnt = tagcnt + 4'd1;
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_cmd_v"}, 64'(o_cmd_v), 64'(0));
        chk({nm, "_tag_r"}, 64'(o_tag_r), 64'(0));
        chk({nm, "_req_r"}, 64'(i_req_r), 64'(0));
        chk({nm, "_busy"}, 64'(o_busy), 64'(0));
        chk({nm, "_tag_e"}, 64'(o_tag_e), 64'(0));
        chk({nm, "_lsb"}, 64'(o_tag_ea_lsb), 64'(0));
        chk({nm, "_nxt"}, 64'(o_tag_ea_lsb_nxt), 64'(0));
        chk({nm, "_cmd_tag"}, 64'(o_cmd_tag), 64'(0));
        chk({nm, "_cmd_ea"}, o_cmd_ea, 64'(0));
        chk({nm, "_cmd_sid"}, 64'(o_cmd_sid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk     = 0;
        n_err     = 0;
        tagcnt    = 4'd3;
        reset     = 1'b0;
        i_req_v   = '0;
        i_req_ea  = '0;
        i_req_len = '0;
        i_tag_v   = 1'b1;
        i_tag_d   = '0;
        i_cmd_r   = 1'b1;
        i_disable = 1'b0;

        #12;
        check_reset_vals("rst");
        #5;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Aligned single full line on stream 0.
        grant(0, 64'h1000, 16'h0080);
        expect_tag("al", 0, 64'h1000, 7'h00, 7'h00, 1'b1);
        @(posedge clk);
        #1;
        chk("al_idle_cmd_v", 64'(o_cmd_v), 64'(0));
        chk("al_idle_busy", 64'(o_busy), 64'(0));

        // Unaligned request straddling two lines on stream 3.
        grant(3, 64'h1F0, 16'h0030);
        expect_tag("ua1", 3, 64'h180, 7'h70, 7'h00, 1'b0);
        expect_tag("ua2", 3, 64'h200, 7'h00, 7'h20, 1'b1);

        // Round robin with all streams requesting, pointer back at 0.
        for (int g = 0; g < 4; g++) begin
            set_slot(g, 64'h2000 + 64'(g) * 64'h1000, 16'h0080, 1'b1);
        end
        for (int g = 0; g < 5; g++) begin
            int k;
            logic [3:0] exp_r;
            k = g % 4;
            exp_r = 4'b1000 >> k;
            #1;
            chk("rr_grant", 64'(i_req_r), 64'(exp_r));
            @(posedge clk);
            #1;
            if (g == 4) i_req_v = '0;
            expect_tag("rr", k, 64'h2000 + 64'(k) * 64'h1000, 7'h00, 7'h00, 1'b1);
        end

        // Command backpressure mid-stream.
        grant(1, 64'h10000, 16'h0200);
        expect_tag("bp1", 1, 64'h10000, 7'h00, 7'h00, 1'b0);
        i_cmd_r = 1'b0;
        repeat (5) begin
            #1;
            chk("bp_tag_r", 64'(o_tag_r), 64'(0));
            chk("bp_hold_ea", o_cmd_ea, 64'h10000);
            @(posedge clk);
        end
        #1;
        i_cmd_r = 1'b1;
        expect_tag("bp2", 1, 64'h10080, 7'h00, 7'h00, 1'b0);
        expect_tag("bp3", 1, 64'h10100, 7'h00, 7'h00, 1'b0);
        expect_tag("bp4", 1, 64'h10180, 7'h00, 7'h00, 1'b1);

        // Zero length: accepted and dropped.
        grant(2, 64'h7000, 16'h0000);
        #1;
        chk("zl_tag_r", 64'(o_tag_r), 64'(0));
        chk("zl_busy", 64'(o_busy), 64'(0));
        @(posedge clk);
        #1;
        chk("zl_cmd_v", 64'(o_cmd_v), 64'(0));

        // Disable during a 4-line stream; another stream waits until release.
        grant(0, 64'h3000, 16'h0200);
        i_disable = 1'b1;
        set_slot(1, 64'h4000, 16'h0080, 1'b1);
        expect_tag("ds1", 0, 64'h3000, 7'h00, 7'h00, 1'b0);
        expect_tag("ds2", 0, 64'h3080, 7'h00, 7'h00, 1'b0);
        expect_tag("ds3", 0, 64'h3100, 7'h00, 7'h00, 1'b0);
        expect_tag("ds4", 0, 64'h3180, 7'h00, 7'h00, 1'b1);
        repeat (3) begin
            #1;
            chk("ds_no_grant", 64'(i_req_r), 64'(0));
            @(posedge clk);
        end
        #1;
        i_disable = 1'b0;
        #1;
        chk("ds_release_grant", 64'(i_req_r), 64'(4'b0100));
        @(posedge clk);
        #1;
        set_slot(1, 64'h4000, 16'h0080, 1'b0);
        expect_tag("ds5", 1, 64'h4000, 7'h00, 7'h00, 1'b1);

        // End address wrapping past 2^64.
        grant(3, 64'hFFFF_FFFF_FFFF_FF80, 16'h0100);
        expect_tag("wr1", 3, 64'hFFFF_FFFF_FFFF_FF80, 7'h00, 7'h00, 1'b0);
        expect_tag("wr2", 3, 64'h0, 7'h00, 7'h00, 1'b1);

        // Mid-stream asynchronous reset after 2 of 4 tags.
        grant(2, 64'h5000, 16'h0200);
        expect_tag("mr1", 2, 64'h5000, 7'h00, 7'h00, 1'b0);
        expect_tag("mr2", 2, 64'h5080, 7'h00, 7'h00, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("mr");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        grant(1, 64'h6040, 16'h0040);
        expect_tag("mr_new", 1, 64'h6000, 7'h40, 7'h00, 1'b1);
        @(posedge clk);
        #1;
        chk("end_busy", 64'(o_busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
